bfly_stage_ctrl: RTL and testbench

//  Sequencer for one parallel radix-2 FFT butterfly stage. Accepts frames of NUM_BEATS

---
 rtl/fft_ctrl_pkg.sv | 32 +++
 rtl/ctrl_delay_line.sv | 31 +++
 rtl/bfly_stage_ctrl.sv | 103 ++++++++++
 tb/tb_bfly_stage_ctrl.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_ctrl_pkg.sv
// Shared types and width helpers for the butterfly stage controller.
package fft_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Beat counter width, never narrower than one bit.
  function automatic int cnt_width(input int num_beats);
    return (num_beats > 2) ? $clog2(num_beats) : 1;
  endfunction

  // Twiddle index width, never narrower than one bit.
  function automatic int tw_width(input int sw_period);
    return (sw_period > 2) ? $clog2(sw_period) : 1;
  endfunction

  localparam int DEF_NUM_BEATS = 32;
  localparam int DEF_SW_PERIOD = 8;
  localparam int DEF_TW_W      = tw_width(DEF_SW_PERIOD);

  // One entry of the delay pipeline that tracks a beat through the datapath.
  typedef struct packed {
    logic                valid;
    logic                last;
    logic                sel;
    logic [DEF_TW_W-1:0] tw;
  } dl_entry_t;

endpackage

// File: rtl/ctrl_delay_line.sv
// Register pipeline that carries beat side-information alongside the butterfly datapath.
module ctrl_delay_line
  import fft_ctrl_pkg::*;
#(
  parameter int  DEPTH = 2,
  parameter type T     = dl_entry_t
) (
  input  logic clk,
  input  logic rstn,
  input  logic flush,
  input  T     d,
  output T     q
);

  T stage [DEPTH];

  // Shift entries one stage per cycle; a flush empties every stage at once.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else begin
      stage[0] <= d;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign q = stage[DEPTH-1];

endmodule

// File: rtl/bfly_stage_ctrl.sv
// Sequencer for one radix-2 butterfly stage: frames beats, drives the add/sub select,
// and emits output valid/last, twiddle index and a frame-done pulse.
module bfly_stage_ctrl
  import fft_ctrl_pkg::*;
#(
  parameter  int NUM_BEATS = DEF_NUM_BEATS,
  parameter  int SW_PERIOD = DEF_SW_PERIOD,
  parameter  int LATENCY   = 2,
  localparam int CNT_W     = cnt_width(NUM_BEATS),
  localparam int TW_W      = tw_width(SW_PERIOD)
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            start,
  input  logic            abort,
  input  logic            in_valid,
  output logic            in_ready,
  output logic            sw,
  output logic            out_valid,
  output logic            out_last,
  output logic [TW_W-1:0] tw_addr,
  output logic            busy,
  output logic            frame_done
);

  localparam int SEL_BIT = $clog2(SW_PERIOD);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             accept;
  logic             last_beat;
  logic             out_last_raw;
  dl_entry_t        entry_in;
  dl_entry_t        entry_out;

  assign accept       = in_ready & in_valid;
  assign last_beat    = (cnt == CNT_W'(NUM_BEATS - 1));
  assign out_last_raw = entry_out.valid & entry_out.last;

  // Side information for the beat being accepted this cycle.
  always_comb begin
    entry_in       = '0;
    entry_in.valid = accept;
    entry_in.last  = last_beat;
    entry_in.sel   = cnt[SEL_BIT];
    entry_in.tw    = DEF_TW_W'(cnt & CNT_W'(SW_PERIOD - 1));
  end

  ctrl_delay_line #(
    .DEPTH (LATENCY),
    .T     (dl_entry_t)
  ) u_delay (
    .clk   (clk),
    .rstn  (rstn),
    .flush (abort),
    .d     (entry_in),
    .q     (entry_out)
  );

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic; abort overrides every other transition.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start && !frame_done)  state_nxt = RUN;
      RUN:     if (accept && last_beat)   state_nxt = DRAIN;
      DRAIN:   if (out_last_raw)          state_nxt = IDLE;
      default:                            state_nxt = IDLE;
    endcase
    if (abort) state_nxt = IDLE;
  end

  // Beat counter advances only on accepted beats and clears after the last one.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)               cnt <= '0;
    else if (abort)          cnt <= '0;
    else if (state == IDLE)  cnt <= '0;
    else if (accept)         cnt <= last_beat ? '0 : cnt + CNT_W'(1);
  end

  // Completion pulse one cycle after the last beat leaves the stage.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) frame_done <= 1'b0;
    else       frame_done <= out_last_raw & ~abort;
  end

  // Output decode; side fields are gated to zero whenever no valid beat is present.
  always_comb begin
    in_ready  = (state == RUN);
    busy      = (state != IDLE);
    out_valid = entry_out.valid;
    sw        = entry_out.valid & entry_out.sel;
    out_last  = entry_out.valid & entry_out.last;
    tw_addr   = entry_out.valid ? entry_out.tw[TW_W-1:0] : '0;
  end

endmodule

// File: tb/tb_bfly_stage_ctrl.sv
// Self-checking bench for bfly_stage_ctrl with a scoreboard of expected output beats.
module tb_bfly_stage_ctrl;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       sw;
  logic       out_valid;
  logic       out_last;
  logic [2:0] tw_addr;
  logic       busy;
  logic       frame_done;

  typedef struct {
    int         cyc;
    logic       sw;
    logic       last;
    logic [2:0] tw;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit mon_en = 1'b0;

  // Reference model state for the current cycle: 0 idle, 1 run, 2 drain.
  int m_state = 0;
  int m_cnt = 0;
  int m_last_cyc = -1;
  int m_fd_cyc = -1;

  bfly_stage_ctrl #(
    .NUM_BEATS (32),
    .SW_PERIOD (8),
    .LATENCY   (2)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .start      (start),
    .abort      (abort),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .sw         (sw),
    .out_valid  (out_valid),
    .out_last   (out_last),
    .tw_addr    (tw_addr),
    .busy       (busy),
    .frame_done (frame_done)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Cycle index used to timestamp expected outputs.
  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: compares every presented beat against the scoreboard.
  always @(negedge clk) begin
    if (mon_en) begin
      checks++;
      if (busy !== (m_state != 0)) begin
        errors++;
        $display("[TB] FAIL busy cyc=%0d got=%b exp=%b", cyc, busy, (m_state != 0));
      end
      checks++;
      if (frame_done !== (cyc == m_fd_cyc)) begin
        errors++;
        $display("[TB] FAIL frame_done cyc=%0d got=%b exp=%b", cyc, frame_done, (cyc == m_fd_cyc));
      end
      if (out_valid === 1'b1) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("[TB] FAIL unexpected_out cyc=%0d got out_valid=1 exp out_valid=0", cyc);
        end else begin
          mon_e = sb.pop_front();
          if (mon_e.cyc != cyc || sw !== mon_e.sw || out_last !== mon_e.last || tw_addr !== mon_e.tw) begin
            errors++;
            $display("[TB] FAIL out_beat cyc=%0d got sw=%b last=%b tw=%0d exp cyc=%0d sw=%b last=%b tw=%0d",
                     cyc, sw, out_last, tw_addr, mon_e.cyc, mon_e.sw, mon_e.last, mon_e.tw);
          end
        end
      end else begin
        checks++;
        if (out_valid !== 1'b0 || sw !== 1'b0 || out_last !== 1'b0 || tw_addr !== 3'd0) begin
          errors++;
          $display("[TB] FAIL gating cyc=%0d got valid=%b sw=%b last=%b tw=%0d exp all 0",
                   cyc, out_valid, sw, out_last, tw_addr);
        end
        if (sb.size() > 0 && sb[0].cyc <= cyc) begin
          checks++;
          errors++;
          $display("[TB] FAIL missing_out cyc=%0d got out_valid=0 exp beat due at cyc=%0d", cyc, sb[0].cyc);
          void'(sb.pop_front());
        end
      end
    end
  end

  // Drive one cycle of inputs, check in_ready, and advance the reference model.
  task automatic step(input logic v, input logic st, input logic ab);
    int n_state;
    int n_cnt;
    in_valid = v;
    start    = st;
    abort    = ab;
    #1;
    checks++;
    if (in_ready !== (m_state == 1)) begin
      errors++;
      $display("[TB] FAIL in_ready cyc=%0d got=%b exp=%b", cyc, in_ready, (m_state == 1));
    end
    n_state = m_state;
    n_cnt   = m_cnt;
    if (m_state == 1 && v) begin
      sb.push_back('{cyc + 2, logic'((m_cnt / 8) % 2), (m_cnt == 31), 3'(m_cnt % 8)});
      if (m_cnt == 31) begin
        n_cnt      = 0;
        n_state    = 2;
        m_last_cyc = cyc + 2;
      end else begin
        n_cnt = m_cnt + 1;
      end
    end
    if (m_state == 0 && st && !ab && cyc != m_fd_cyc) begin
      n_state = 1;
      n_cnt   = 0;
    end
    if (m_state == 2 && cyc == m_last_cyc && !ab) begin
      n_state  = 0;
      m_fd_cyc = cyc + 1;
    end
    if (ab && m_state != 0) begin
      n_state    = 0;
      n_cnt      = 0;
      m_last_cyc = -1;
      for (int i = sb.size() - 1; i >= 0; i--) begin
        if (sb[i].cyc > cyc) sb.delete(i);
      end
    end
    @(posedge clk);
    m_state = n_state;
    m_cnt   = n_cnt;
    #1;
  endtask

  // Run beats until the model leaves RUN, then drain; every loop is bounded.
  task automatic run_frame(input bit gaps, input bit with_start);
    if (with_start) step(1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 200 && m_state == 1; k++) step(gaps ? logic'(k % 2 == 0) : 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 10 && m_state != 0; k++) step(1'b0, 1'b0, 1'b0);
    checks++;
    if (m_state != 0) begin
      errors++;
      $display("[TB] FAIL frame_bound got model_state=%0d exp 0", m_state);
    end
  endtask

  // Idle a few cycles and confirm every expected beat has been seen.
  task automatic check_drained(input string name);
    for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 1'b0);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL %s_drained got pending=%0d exp 0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic check_all_zero(input string name);
    checks++;
    if ({in_ready, sw, out_valid, out_last, tw_addr, busy, frame_done} !== 9'd0) begin
      errors++;
      $display("[TB] FAIL %s got rdy=%b sw=%b val=%b last=%b tw=%0d busy=%b fd=%b exp all 0",
               name, in_ready, sw, out_valid, out_last, tw_addr, busy, frame_done);
    end
  endtask

  task automatic model_reset();
    m_state    = 0;
    m_cnt      = 0;
    m_last_cyc = -1;
    m_fd_cyc   = -1;
    sb.delete();
  endtask

  task automatic test_reset();
    $display("[TB] test_reset");
    rstn = 1'b0;
    in_valid = 1'b1;
    start = 1'b1;
    repeat (3) @(negedge clk);
    check_all_zero("reset_hold");
    start = 1'b0;
    rstn = 1'b1;
    @(posedge clk);
    #1;
    model_reset();
    mon_en = 1'b1;
    for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    $display("[TB] test_back_to_back");
    run_frame(1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0);
    run_frame(1'b0, 1'b1);
    check_drained("back_to_back");
  endtask

  task automatic test_bubbles();
    $display("[TB] test_bubbles");
    run_frame(1'b1, 1'b1);
    check_drained("bubbles");
  endtask

  task automatic test_abort();
    $display("[TB] test_abort");
    step(1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 10; k++) step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    for (int k = 0; k < 5; k++) step(1'b1, 1'b0, 1'b0);
    run_frame(1'b0, 1'b1);
    check_drained("abort");
  endtask

  task automatic test_async_reset();
    $display("[TB] test_async_reset");
    step(1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 20; k++) step(1'b1, 1'b0, 1'b0);
    in_valid = 1'b1;
    #2;
    mon_en = 1'b0;
    rstn = 1'b0;
    #1;
    check_all_zero("async_reset");
    model_reset();
    @(negedge clk);
    in_valid = 1'b0;
    rstn = 1'b1;
    @(posedge clk);
    #1;
    mon_en = 1'b1;
    for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 1'b0);
    run_frame(1'b0, 1'b1);
    check_drained("async_reset");
  endtask

  task automatic test_start_abort_mix();
    $display("[TB] test_start_abort_mix");
    step(1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 5; k++) step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    run_frame(1'b0, 1'b0);
    check_drained("start_in_run");
    step(1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    check_drained("abort_start");
  endtask

  // Global watchdog so the run can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog got timeout exp finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Test sequence.
  initial begin
    test_reset();
    test_back_to_back();
    test_bubbles();
    test_abort();
    test_async_reset();
    test_start_abort_mix();
    mon_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
